// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the memory arbiter
package mem_arbiter_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;

  typedef enum logic [1:0] {
    STAT_IDLE = 2'b00,
    STAT_BUSY = 2'b01,
    STAT_DONE = 2'b10
  } status_e;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  // Width code 3 is illegal and deliberately falls through to a word transfer.
  function automatic logic [2:0] width_len(input logic [1:0] width);
    case (width)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// rtl/mem_byte_seq.sv - issue/capture counters and little-endian assembly for one transfer
module mem_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [2:0]         start_len,
  input  logic               run,
  input  logic               rd,
  input  logic [7:0]         din,
  output logic [ADDR_W-1:0]  issue_addr,
  output logic [1:0]         issue_idx,
  output logic               issue_left,
  output logic               cap_ready,
  output logic               cap_last,
  output logic [InstLen-1:0] assembled
);

  logic [ADDR_W-1:0]  base;
  logic [2:0]         len;
  logic [2:0]         i;
  logic [1:0]         j;
  logic               cap_en;
  logic [InstLen-1:0] buffer;

  // The first address goes out on the start edge, so i starts at 1 and the
  // first returning byte is one cycle behind the first RD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base   <= '0;
      len    <= '0;
      i      <= '0;
      j      <= '0;
      cap_en <= 1'b0;
      buffer <= '0;
    end else if (start) begin
      base   <= start_addr;
      len    <= start_len;
      i      <= 3'd1;
      j      <= 2'd0;
      cap_en <= 1'b0;
      buffer <= '0;
    end else if (run) begin
      if (i < len) i <= i + 3'd1;
      cap_en <= rd;
      if (rd && cap_en) begin
        buffer <= assembled;
        j      <= j + 2'd1;
      end
    end
  end

  assign issue_addr = base + ADDR_W'(i);
  assign issue_idx  = i[1:0];
  assign issue_left = (i < len);
  assign cap_ready  = cap_en;
  assign cap_last   = (({1'b0, j} + 3'd1) == len);
  assign assembled  = buffer | (InstLen'(din) << {j, 3'b000});

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port byte RAM arbiter between instruction fetch and memory access
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [AddrLen-1:0] if_addr,
  input  logic               if_abort,
  output logic [1:0]         if_status,
  output logic [InstLen-1:0] if_data,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [1:0]         mem_width,
  input  logic [AddrLen-1:0] mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [1:0]         mem_status,
  output logic [31:0]        mem_rdata,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_wr,
  output logic [7:0]         ram_dout,
  input  logic [7:0]         ram_din
);

  state_e             state;
  owner_e             owner;
  logic [31:0]        wdata;
  logic               start;
  logic               start_we;
  logic [ADDR_W-1:0]  start_addr;
  logic [2:0]         start_len;
  logic               run;
  logic               rd;
  logic               abort;
  logic [ADDR_W-1:0]  issue_addr;
  logic [1:0]         issue_idx;
  logic               issue_left;
  logic               cap_ready;
  logic               cap_last;
  logic [InstLen-1:0] assembled;
  logic               unused_addr_hi;

  // MEM has fixed priority; IF only starts when MEM is quiet and no redirect is pending.
  always_comb begin
    start      = 1'b0;
    start_we   = 1'b0;
    start_addr = mem_addr[ADDR_W-1:0];
    start_len  = width_len(mem_width);
    if (state == S_IDLE) begin
      if (mem_req) begin
        start    = 1'b1;
        start_we = mem_we;
      end else if (if_req && !if_abort) begin
        start      = 1'b1;
        start_addr = if_addr[ADDR_W-1:0];
        start_len  = 3'(InstLen / 8);
      end
    end
  end

  assign run            = (state == S_RD) || (state == S_WR);
  assign rd             = (state == S_RD);
  assign abort          = rd && (owner == OWN_IF) && if_abort;
  assign unused_addr_hi = ^{if_addr[AddrLen-1:ADDR_W], mem_addr[AddrLen-1:ADDR_W]};

  mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .run        (run),
    .rd         (rd),
    .din        (ram_din),
    .issue_addr (issue_addr),
    .issue_idx  (issue_idx),
    .issue_left (issue_left),
    .cap_ready  (cap_ready),
    .cap_last   (cap_last),
    .assembled  (assembled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      wdata      <= '0;
      if_status  <= STAT_IDLE;
      mem_status <= STAT_IDLE;
      if_data    <= '0;
      mem_rdata  <= '0;
      ram_addr   <= '0;
      ram_wr     <= 1'b0;
      ram_dout   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            owner    <= mem_req ? OWN_MEM : OWN_IF;
            state    <= start_we ? S_WR : S_RD;
            wdata    <= mem_wdata;
            ram_addr <= start_addr;
            ram_wr   <= start_we;
            if (start_we) ram_dout <= mem_wdata[7:0];
            if (mem_req) mem_status <= STAT_BUSY;
            else         if_status  <= STAT_BUSY;
          end
        end
        S_RD: begin
          if (abort) begin
            state     <= S_IDLE;
            if_status <= STAT_IDLE;
          end else begin
            if (issue_left) ram_addr <= issue_addr;
            if (cap_ready && cap_last) begin
              state <= S_DONE;
              if (owner == OWN_MEM) begin
                mem_status <= STAT_DONE;
                mem_rdata  <= assembled;
              end else begin
                if_status <= STAT_DONE;
                if_data   <= assembled;
              end
            end
          end
        end
        S_WR: begin
          if (issue_left) begin
            ram_addr <= issue_addr;
            ram_dout <= wdata[{issue_idx, 3'b000} +: 8];
          end else begin
            ram_wr     <= 1'b0;
            state      <= S_DONE;
            mem_status <= STAT_DONE;
          end
        end
        default: begin
          state      <= S_IDLE;
          if_status  <= STAT_IDLE;
          mem_status <= STAT_IDLE;
          ram_wr     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_abort = 1'b0;
  logic [1:0]        if_status;
  logic [31:0]       if_data;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [1:0]        mem_width = '0;
  logic [31:0]       mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic [1:0]        mem_status;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  logic [7:0]  ram [0:(1<<ADDR_W)-1];
  int          checks = 0;
  int          errors = 0;
  int          n_writes = 0;
  logic [31:0] exp_if[$];
  logic [32:0] exp_mem[$];
  logic [31:0] e_if;
  logic [32:0] e_mem;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_abort   (if_abort),
    .if_status  (if_status),
    .if_data    (if_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_width  (mem_width),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_status (mem_status),
    .mem_rdata  (mem_rdata),
    .ram_addr   (ram_addr),
    .ram_wr     (ram_wr),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
      n_writes      <= n_writes + 1;
    end
    ram_din <= ram[ram_addr];
  end

  // Scoreboard: every DONE must match the oldest expected result of that requester.
  always @(negedge clk) begin
    if (!rst && if_status == STAT_DONE) begin
      checks++;
      if (exp_if.size() == 0) begin
        errors++;
        $display("FAIL if_unexpected_done: got data %h, required no DONE", if_data);
      end else begin
        e_if = exp_if.pop_front();
        if (if_data !== e_if) begin
          errors++;
          $display("FAIL if_data: got %h, required %h", if_data, e_if);
        end
      end
    end
    if (!rst && mem_status == STAT_DONE) begin
      checks++;
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected_done: got data %h, required no DONE", mem_rdata);
      end else begin
        e_mem = exp_mem.pop_front();
        if (e_mem[32] && mem_rdata !== e_mem[31:0]) begin
          errors++;
          $display("FAIL mem_rdata: got %h, required %h", mem_rdata, e_mem[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({if_status, mem_status} !== 4'b0) begin
      errors++;
      $display("FAIL reset_status: got %b, required 0000", {if_status, mem_status});
    end
    checks++;
    if ({if_data, mem_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h, required 0 0", if_data, mem_rdata);
    end
    checks++;
    if ({ram_wr, ram_addr, ram_dout} !== '0) begin
      errors++;
      $display("FAIL reset_ram_port: got wr=%b addr=%h dout=%h, required 0", ram_wr, ram_addr, ram_dout);
    end
  endtask

  task automatic test_word_fetch();
    logic [1:0] exp_st;
    if_req  = 1'b1;
    if_addr = 32'h100;
    exp_if.push_back(32'h00100513);
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp_st = (c <= 5) ? STAT_BUSY : (c == 6) ? STAT_DONE : STAT_IDLE;
      checks++;
      if (if_status !== exp_st) begin
        errors++;
        $display("FAIL fetch_status c%0d: got %0d, required %0d", c, if_status, exp_st);
      end
      if (c <= 4) begin
        checks++;
        if (ram_addr !== ADDR_W'(32'h100 + c - 1) || ram_wr !== 1'b0) begin
          errors++;
          $display("FAIL fetch_addr c%0d: got %h wr=%b, required %h wr=0", c, ram_addr, ram_wr,
                   ADDR_W'(32'h100 + c - 1));
        end
      end
      if (c == 6) if_req = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_m, exp_i;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_width = W_BYTE;
    mem_addr  = 32'h200;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    exp_mem.push_back({1'b1, 32'h000000AB});
    exp_if.push_back(32'h00100513);
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_m = (c <= 2) ? STAT_BUSY : (c == 3) ? STAT_DONE : STAT_IDLE;
      exp_i = (c <= 4) ? STAT_IDLE : (c <= 9) ? STAT_BUSY : (c == 10) ? STAT_DONE : STAT_IDLE;
      checks++;
      if (mem_status !== exp_m || if_status !== exp_i) begin
        errors++;
        $display("FAIL simul_status c%0d: got mem=%0d if=%0d, required mem=%0d if=%0d",
                 c, mem_status, if_status, exp_m, exp_i);
      end
      if (c == 3) mem_req = 1'b0;
      if (c == 10) if_req = 1'b0;
    end
  endtask

  task automatic test_store_half();
    logic [25:0] exp_port;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_width = W_HALF;
    mem_addr  = 32'h0001FFFF;
    mem_wdata = 32'hDEADBEEF;
    exp_mem.push_back({1'b0, 32'h0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        exp_port = (c == 1) ? {1'b1, 17'h1FFFF, 8'hEF} : {1'b1, 17'h00000, 8'hBE};
        checks++;
        if ({ram_wr, ram_addr, ram_dout} !== exp_port) begin
          errors++;
          $display("FAIL store_port c%0d: got %h, required %h", c, {ram_wr, ram_addr, ram_dout}, exp_port);
        end
      end else begin
        exp_port = (c == 3) ? {24'h0, STAT_DONE} : {24'h0, STAT_IDLE};
        checks++;
        if ({ram_wr, 23'h0, mem_status} !== exp_port[25:0]) begin
          errors++;
          $display("FAIL store_done c%0d: got wr=%b status=%0d, required wr=0 status=%0d",
                   c, ram_wr, mem_status, exp_port[1:0]);
        end
      end
      if (c == 1) begin
        mem_wdata = 32'h0;
        mem_addr  = 32'h5000;
        mem_width = W_BYTE;
      end
      if (c == 3) mem_req = 1'b0;
    end
    checks++;
    if (ram[17'h1FFFF] !== 8'hEF || ram[17'h0] !== 8'hBE) begin
      errors++;
      $display("FAIL store_ram: got %h %h, required ef be", ram[17'h1FFFF], ram[17'h0]);
    end
    mem_we = 1'b0;
  endtask

  task automatic test_abort();
    logic [1:0] exp_st;
    int k;
    if_req  = 1'b1;
    if_addr = 32'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_st = (c <= 3) ? STAT_BUSY : STAT_IDLE;
      checks++;
      if (if_status !== exp_st) begin
        errors++;
        $display("FAIL abort_status c%0d: got %0d, required %0d", c, if_status, exp_st);
      end
      if (c == 3) if_abort = 1'b1;
    end
    if_abort = 1'b0;
    if_addr  = 32'h100;
    exp_if.push_back(32'h00100513);
    for (k = 1; k <= 20; k++) begin
      tick();
      if (if_status == STAT_DONE) break;
    end
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL abort_refetch_latency: got %0d cycles, required 6", k);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    int writes_before;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_width = W_WORD;
    mem_addr  = 32'h300;
    mem_wdata = 32'h11223344;
    tick();
    tick();
    checks++;
    if (ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL midstore_active: got wr=%b, required 1", ram_wr);
    end
    #2;
    rst     = 1'b1;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    #1;
    checks++;
    if ({ram_wr, ram_addr, if_status, mem_status} !== '0) begin
      errors++;
      $display("FAIL midstore_async: got wr=%b addr=%h st=%0d/%0d, required all 0",
               ram_wr, ram_addr, if_status, mem_status);
    end
    writes_before = n_writes;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ram_wr !== 1'b0 || mem_status !== STAT_IDLE) begin
        errors++;
        $display("FAIL midstore_after c%0d: got wr=%b status=%0d, required wr=0 status=0", c, ram_wr, mem_status);
      end
    end
    checks++;
    if (n_writes != writes_before || ram[17'h300] !== 8'h44 || ram[17'h301] !== 8'h00) begin
      errors++;
      $display("FAIL midstore_ram: got writes=%0d ram=%h %h, required writes=%0d ram=44 00",
               n_writes, ram[17'h300], ram[17'h301], writes_before);
    end
  endtask

  task automatic test_load_word();
    int first_done, done_cycles;
    for (int w = 2; w <= 3; w++) begin
      mem_req   = 1'b1;
      mem_we    = 1'b0;
      mem_width = 2'(w);
      mem_addr  = 32'h10;
      exp_mem.push_back({1'b1, 32'h04030201});
      first_done  = 0;
      done_cycles = 0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (mem_status == STAT_DONE) begin
          done_cycles++;
          if (first_done == 0) first_done = c;
          mem_req = 1'b0;
        end
      end
      checks++;
      if (first_done != 6 || done_cycles != 1) begin
        errors++;
        $display("FAIL load_word w%0d: got done at %0d for %0d cycles, required 6 for 1", w, first_done, done_cycles);
      end
    end
  endtask

  initial begin
    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h10; ram[17'h103] = 8'h00;
    ram[17'h200] = 8'hAB;
    ram[17'h10]  = 8'h01; ram[17'h11]  = 8'h02; ram[17'h12]  = 8'h03; ram[17'h13]  = 8'h04;
    ram[17'h1FFFF] = 8'h00; ram[17'h0] = 8'h00;
    ram[17'h300] = 8'h00; ram[17'h301] = 8'h00;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_word_fetch();
    test_simultaneous();
    test_store_half();
    test_abort();
    test_reset_mid_store();
    test_load_word();
    tick();
    checks++;
    if (exp_if.size() != 0 || exp_mem.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", exp_if.size(), exp_mem.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the single byte-wide synchronous RAM port.
- Arbitrates between the instruction-fetch stage (IF, word reads only) and the memory-access stage (MEM, byte/half/word loads and stores).
- Sequences multi-byte transfers, assembles little-endian words and reports per-requester status as IDLE/BUSY/DONE.
- IF drives its request while waiting for DONE and consumes DONE in the same cycle.

Parameters:
ADDR_W, 17, RAM address width; the low ADDR_W bits of the 32-bit requester addresses are used.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_req  in  1  IF read request; held until if_status==DONE
if_addr  in  32  IF fetch address
if_abort  in  1  cancel the in-flight IF fetch (branch redirect)
if_status  out  2  IF status: IDLE/BUSY/DONE
if_data  out  32  fetched instruction; valid only while if_status==DONE
mem_req  in  1  MEM request; held until mem_status==DONE
mem_we  in  1  1=store, 0=load
mem_width  in  2  0=byte, 1=half, 2=word (3 is illegal and treated as word)
mem_addr  in  32  MEM byte address
mem_wdata  in  32  store data; byte k is bits [8k+7:8k]
mem_status  out  2  MEM status: IDLE/BUSY/DONE
mem_rdata  out  32  load data, zero-extended; valid only while mem_status==DONE
ram_addr  out  ADDR_W  RAM address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write data
ram_din  in  8  RAM read data, one cycle after the address

Behaviour:
- Reset (async): state=IDLE; both status outputs IDLE; if_data, mem_rdata, ram_addr and ram_dout = 0; ram_wr=0 immediately.
- Reset asserted mid-transfer abandons the transfer. No DONE is issued.
- States: IDLE, RD, WR, DONE. Registers:
  - owner (IF/MEM)
  - base address, n bytes (1/2/4)
  - issue counter i
  - capture counter j
  - 32-bit assembly buffer
- IDLE, request sampling at a clock edge:
  - mem_req=1 wins: go to WR if mem_we=1, else RD; owner=MEM.
  - Otherwise, if_req=1 and if_abort=0: go to RD with n=4; owner=IF.
  - The loser's status stays IDLE while it waits.
- Owner status is BUSY throughout RD/WR. The non-owner's status stays IDLE.
- Define cycle 0 as the cycle in which the request is sampled.
- RD:
  - Cycles 1..n: ram_addr=base+(cycle-1), ram_wr=0.
  - Byte k appears on ram_din in cycle k+2 and is stored into buffer bits [8k+7:8k].
  - Unused upper bytes are 0. Latency: byte read DONE in cycle 3, half in cycle 4, word in cycle 6.
- WR:
  - Cycles 1..n: ram_wr=1, ram_addr=base+(cycle-1), ram_dout=mem_wdata byte (cycle-1).
  - DONE in cycle n+1.
- DONE:
  - Exactly one cycle. Owner status=DONE, with data presented on the owner's data port.
  - Non-owner status=IDLE; ram_wr=0.
  - Next state is always IDLE. Requests are not sampled during the DONE cycle, so the earliest back-to-back start is 2 cycles after DONE.
- Address arithmetic is modulo 2^ADDR_W: base+k wraps from all-ones to 0.
- if_abort:
  - Sampled high during RD with owner=IF: next state is IDLE, if_status goes IDLE, no DONE is issued, and the partial buffer is discarded. A read byte already in flight is ignored.
  - In a DONE cycle it has no effect, because the data has already been delivered.
  - It has no effect on MEM-owned transfers.
  - Held high in IDLE together with if_req, it blocks the IF start.
- Input stability: if_addr, mem_addr, mem_wdata, mem_width and mem_we are captured at start. Later changes while BUSY are ignored.
- if_data and mem_rdata hold their last value outside DONE; consumers must qualify them with status.
- Starvation: MEM priority is fixed. IF gets the port whenever mem_req is low in IDLE.

Decomposition:
- Shared package:
  - status encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10
  - width codes BYTE=0, HALF=1, WORD=2
  - state encoding
  - AddrLen/InstLen constants, already common to the pipeline
- One natural sub-module, mem_byte_seq: the issue/capture counters and little-endian assembly for a single transfer of n bytes. The arbiter top holds owner selection, the FSM and status fan-out.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,05,10,00; if_req, if_addr=0x100 -> ram_addr 0x100..0x103 in cycles 1-4, if_status BUSY cycles 1-5, DONE in cycle 6 with if_data=0x00100513, IDLE in cycle 7.
- Simultaneous requests: if_req and mem_req (load byte @0x200, RAM=0xAB) in the same cycle -> MEM served first, mem_status DONE in cycle 3 with mem_rdata=0x000000AB; if_status stays IDLE; IF starts on the next IDLE sampling and completes.
- Store half: mem_we=1, mem_width=1, addr=0x1FFFF, wdata=0xDEADBEEF -> ram_wr=1 in cycles 1-2, with (0x1FFFF, 0xEF) then (0x00000, 0xBE); DONE in cycle 3.
- Abort: IF fetch started, if_abort=1 in cycle 3 -> if_status IDLE in cycle 4, never DONE; a following fetch returns correct data.
- Reset mid-store: rst asserted in cycle 2 of a word store -> ram_wr=0 without waiting for a clock edge, both status outputs IDLE, no further RAM writes.
- Load word little-endian: RAM[0x10..0x13]=01,02,03,04 -> mem_rdata=0x04030201 with mem_status DONE for exactly one cycle.
